// File: rtl/encoder_x4_pkg.sv
// -----------------------------------------------------------------------------
// encoder_x4_pkg
// Shared constants for the 4-input priority encoder.
//   ENC_IN_W  : number of request lines
//   ENC_IDX_W : width of the encoded index
//   IDX_RESET : index value held while in reset or when nothing is requested
// -----------------------------------------------------------------------------
package encoder_x4_pkg;

    localparam int ENC_IN_W  = 4;
    localparam int ENC_IDX_W = 2;

    localparam logic [ENC_IDX_W-1:0] IDX_RESET = 2'b00;

endpackage : encoder_x4_pkg

// File: rtl/encoder_x4_comb.sv
// -----------------------------------------------------------------------------
// encoder_x4_comb
// Purely combinational priority logic: reports the index of the highest set
// bit of x and whether any bit is set at all.
// Ports:
//   x     in  [ENC_IN_W-1:0]  request vector, x[3] highest priority
//   idx   out [ENC_IDX_W-1:0] index of highest asserted bit (00 when none)
//   valid out                 1 when any bit of x is set
// -----------------------------------------------------------------------------
module encoder_x4_comb
    import encoder_x4_pkg::*;
(
    input  logic [ENC_IN_W-1:0]  x,
    output logic [ENC_IDX_W-1:0] idx,
    output logic                 valid
);

    // Highest bit wins; the all-zero case falls through to the reset index so
    // downstream sees 00 whenever valid is low.
    always_comb begin
        idx   = IDX_RESET;
        valid = 1'b0;
        if (x[3]) begin
            idx   = 2'b11;
            valid = 1'b1;
        end else if (x[2]) begin
            idx   = 2'b10;
            valid = 1'b1;
        end else if (x[1]) begin
            idx   = 2'b01;
            valid = 1'b1;
        end else if (x[0]) begin
            idx   = 2'b00;
            valid = 1'b1;
        end
    end

endmodule : encoder_x4_comb

// File: rtl/encoder_x4.sv
// -----------------------------------------------------------------------------
// encoder_x4
// 4-input priority encoder with registered outputs (one cycle latency).
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous, active-high reset; clears all outputs
//   x    in   [3:0] request vector, x[3] highest priority
//   y    out  valid: some bit of x was set at the last sampling edge
//   z1   out  MSB of encoded index
//   z0   out  LSB of encoded index
// -----------------------------------------------------------------------------
module encoder_x4
    import encoder_x4_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ENC_IN_W-1:0] x,
    output logic                y,
    output logic                z1,
    output logic                z0
);

    logic [ENC_IDX_W-1:0] idx_d;
    logic [ENC_IDX_W-1:0] idx_q;
    logic                 valid_d;
    logic                 valid_q;

    encoder_x4_comb u_comb (
        .x     (x),
        .idx   (idx_d),
        .valid (valid_d)
    );

    // Output register; outputs come straight from these flops so they are
    // glitch-free and ignore x activity between edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= IDX_RESET;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign y  = valid_q;
    assign z1 = idx_q[1];
    assign z0 = idx_q[0];

endmodule : encoder_x4

// File: tb/tb_encoder_x4.sv
// -----------------------------------------------------------------------------
// tb_encoder_x4
// Directed self-checking bench for encoder_x4.
// -----------------------------------------------------------------------------
module tb_encoder_x4;

    logic       clk;
    logic       rst;
    logic [3:0] x;
    logic       y;
    logic       z1;
    logic       z0;

    int test_count;
    int fail_count;

    encoder_x4 dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .z1  (z1),
        .z0  (z0)
    );

    // 10 time-unit clock, first rising edge at t=5
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge so outputs have settled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {y, z1, z0} against the hand-computed expectation
    task automatic check_output(input string tag, input logic exp_y, input logic [1:0] exp_idx);
        logic [2:0] observed;
        logic [2:0] expected;
        observed = {y, z1, z0};
        expected = {exp_y, exp_idx};
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $display("[TB] FAIL %s: observed y,z1,z0=%b expected %b", tag, observed, expected);
            $error("[TB] %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        rst = 1'b0;
        x   = 4'b1111;

        // Reset asserted between edges must clear outputs without a clock edge
        #1 rst = 1'b1;
        #1 check_output("reset_async", 1'b0, 2'b00);
        tick();
        tick();
        check_output("reset_held_edges", 1'b0, 2'b00);

        // Release reset away from an edge; first sample on the next edge
        #2 rst = 1'b0;
        #1 check_output("reset_release_no_edge", 1'b0, 2'b00);
        tick();
        check_output("after_reset_1111", 1'b1, 2'b11);

        // One-hot sweep, each result one cycle after it is applied
        x = 4'b0001;
        tick();
        check_output("onehot_0001", 1'b1, 2'b00);
        x = 4'b0010;
        tick();
        check_output("onehot_0010", 1'b1, 2'b01);
        x = 4'b0100;
        tick();
        check_output("onehot_0100", 1'b1, 2'b10);
        x = 4'b1000;
        tick();
        check_output("onehot_1000", 1'b1, 2'b11);

        // Latency: changing x just after an edge must not show before the next
        x = 4'b0001;
        #2 check_output("latency_hold", 1'b1, 2'b11);
        tick();
        check_output("latency_update", 1'b1, 2'b00);

        // Multiple bits set: highest index wins
        x = 4'b0011;
        tick();
        check_output("prio_0011", 1'b1, 2'b01);
        x = 4'b0110;
        tick();
        check_output("prio_0110", 1'b1, 2'b10);
        x = 4'b1001;
        tick();
        check_output("prio_1001", 1'b1, 2'b11);
        x = 4'b1111;
        tick();
        check_output("prio_1111", 1'b1, 2'b11);

        // Idle then a request
        x = 4'b0000;
        tick();
        check_output("idle_0000", 1'b0, 2'b00);
        tick();
        check_output("idle_hold", 1'b0, 2'b00);
        x = 4'b0100;
        tick();
        check_output("after_idle_0100", 1'b1, 2'b10);

        // Hold: stable x keeps outputs stable over several edges
        tick();
        tick();
        tick();
        check_output("hold_0100", 1'b1, 2'b10);

        // Mid-cycle toggling: only the value present at the edge matters
        x = 4'b0001;
        #2 x = 4'b1000;
        #2 x = 4'b0001;
        #1 check_output("midcycle_before_edge", 1'b1, 2'b10);
        tick();
        check_output("midcycle_after_edge", 1'b1, 2'b00);

        // Async reset pulse mid-stream
        x = 4'b1000;
        tick();
        check_output("pre_pulse_1000", 1'b1, 2'b11);
        #1 rst = 1'b1;
        #1 check_output("pulse_clear", 1'b0, 2'b00);
        rst = 1'b0;
        #1 check_output("pulse_stay_cleared", 1'b0, 2'b00);
        tick();
        check_output("pulse_resume", 1'b1, 2'b11);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule : tb_encoder_x4
